// File: rtl/eeg_bandpower_accum.sv
// Per-channel band-power integrator: squares channel-interleaved samples, integrates them
// over 2^WIN_LOG2-sample windows and queues each window's mean-square power in a FWFT FIFO.
module eeg_bandpower_accum #(
  parameter int N_CH       = 8,
  parameter int CH_W       = 3,
  parameter int DATA_W     = 24,
  parameter int IN_W       = 16,
  parameter int WIN_LOG2   = 6,
  parameter int POW_W      = 32,
  parameter int SAT_THRESH = 32767,
  parameter int FREEZE_CYC = 256,
  parameter int OUT_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [CH_W-1:0]   sample_ch,
  input  logic              sample_valid,
  output logic [POW_W-1:0]  pow_out,
  output logic [CH_W-1:0]   pow_ch,
  output logic              pow_valid,
  input  logic              pow_ready,
  output logic              sat_freeze,
  output logic              overrun
);

  localparam int SQ_W  = 2 * IN_W;
  localparam int ACC_W = SQ_W + WIN_LOG2;
  localparam int CMP_W = (ACC_W > POW_W) ? ACC_W : POW_W;
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int FRZ_W = (FREEZE_CYC > 1) ? $clog2(FREEZE_CYC) : 1;

  typedef enum logic {RUN, FREEZE} sat_state_e;

  // ---------------- input qualification and saturation detect ----------------
  logic signed [IN_W-1:0] x_in;
  logic signed [IN_W:0]   x_wide;
  logic [IN_W:0]          mag_in;
  logic                   in_range, sat_event, accept;

  assign x_in      = signed'(sample_in[DATA_W-1 -: IN_W]);
  assign x_wide    = (IN_W+1)'(x_in);
  // One extra bit so the most negative code reports its true magnitude.
  assign mag_in    = x_wide[IN_W] ? unsigned'(-x_wide) : unsigned'(x_wide);
  assign in_range  = ({1'b0, sample_ch} < (CH_W+1)'(N_CH));
  assign sat_event = sample_valid & in_range & (mag_in >= (IN_W+1)'(SAT_THRESH));
  assign accept    = sample_valid & in_range & ~sat_freeze;

  if (DATA_W > IN_W) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^sample_in[DATA_W-IN_W-1:0];
  end

  // ---------------- S1 / S2: capture and square ----------------
  logic signed [IN_W-1:0] x1;
  logic [CH_W-1:0]        ch1, ch2;
  logic                   v1, v2;
  logic signed [SQ_W-1:0] x1_ext, prod1;
  logic [SQ_W-1:0]        sq2;

  assign x1_ext = SQ_W'(x1);
  assign prod1  = x1_ext * x1_ext;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      x1  <= '0;
      ch1 <= '0;
      v2  <= 1'b0;
      sq2 <= '0;
      ch2 <= '0;
    end else begin
      v1  <= accept & ~sat_event;
      x1  <= x_in;
      ch1 <= sample_ch;
      v2  <= v1 & ~sat_event;
      sq2 <= unsigned'(prod1);
      ch2 <= ch1;
    end
  end

  // ---------------- S3: per-channel accumulate ----------------
  logic [ACC_W-1:0]    acc [N_CH];
  logic [WIN_LOG2-1:0] cnt [N_CH];
  logic [ACC_W-1:0]    acc_sel, acc_final, acc_shift;
  logic [WIN_LOG2-1:0] cnt_sel;
  logic [CMP_W-1:0]    shift_ext;
  logic [POW_W-1:0]    win_pow;
  logic                win_done;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    acc_sel = '0;
    cnt_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch2 == CH_W'(i)) begin
        acc_sel = acc[i];
        cnt_sel = cnt[i];
      end
    end
  end

  // Reading the register file combinationally makes same-channel back-to-back updates see
  // the previous cycle's result without a separate bypass.
  assign acc_final = acc_sel + ACC_W'(sq2);
  assign win_done  = v2 & (cnt_sel == '1) & ~sat_event;
  assign acc_shift = acc_final >> WIN_LOG2;
  assign shift_ext = CMP_W'(acc_shift);
  assign win_pow   = (shift_ext > CMP_W'({POW_W{1'b1}})) ? '1 : POW_W'(shift_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sat_event) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end else if (v2 && ch2 == CH_W'(i)) begin
          cnt[i] <= cnt_sel + 1'b1;
          acc[i] <= win_done ? '0 : acc_final;
        end
      end
    end
  end

  // ---------------- output FIFO (first-word fall-through) ----------------
  logic [POW_W-1:0] fifo_pow [OUT_DEPTH];
  logic [CH_W-1:0]  fifo_ch  [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             full, pop, do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (fifo_cnt == (PTR_W+1)'(OUT_DEPTH));
  assign pop     = pow_valid & pow_ready;
  assign do_push = win_done & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= win_done & full & ~pop;
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: storage array has no reset; the outputs below are gated by pow_valid instead.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_pow[wr_ptr] <= win_pow;
      fifo_ch[wr_ptr]  <= ch2;
    end
  end

  assign pow_valid = (fifo_cnt != '0);
  assign pow_out   = pow_valid ? fifo_pow[rd_ptr] : '0;
  assign pow_ch    = pow_valid ? fifo_ch[rd_ptr]  : '0;

  // ---------------- saturation guard ----------------
  sat_state_e       state, state_nx;
  logic [FRZ_W-1:0] frz_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (sat_event) state_nx = FREEZE;
      FREEZE:  if (!sat_event && frz_cnt == '0) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    sat_freeze = (state == FREEZE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frz_cnt <= '0;
    end else if (sat_event) begin
      frz_cnt <= FRZ_W'(FREEZE_CYC - 1);
    end else if (state == FREEZE && frz_cnt != '0) begin
      frz_cnt <= frz_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_eeg_bandpower_accum.sv
// Bench for eeg_bandpower_accum: directed window/saturation/FIFO scenarios plus randomized
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_eeg_bandpower_accum;

  localparam int N_CH = 8, CH_W = 3, DATA_W = 24, IN_W = 16, WIN_LOG2 = 6, POW_W = 32;
  localparam int SAT_THRESH = 32767, FREEZE_CYC = 256, OUT_DEPTH = 4;
  localparam int WIN = 1 << WIN_LOG2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic [CH_W-1:0]   sample_ch = '0;
  logic              sample_valid = 1'b0;
  logic              pow_ready = 1'b0;
  logic [POW_W-1:0]  pow_out, pow_out6;
  logic [CH_W-1:0]   pow_ch, pow_ch6;
  logic              pow_valid, pow_valid6, sat_freeze, sat_freeze6, overrun, overrun6;

  eeg_bandpower_accum #(.N_CH(N_CH)) u_dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .pow_out(pow_out), .pow_ch(pow_ch), .pow_valid(pow_valid),
    .pow_ready(pow_ready), .sat_freeze(sat_freeze), .overrun(overrun)
  );

  eeg_bandpower_accum #(.N_CH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .pow_out(pow_out6), .pow_ch(pow_ch6), .pow_valid(pow_valid6),
    .pow_ready(pow_ready), .sat_freeze(sat_freeze6), .overrun(overrun6)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; int ch; int x; } samp_t;
  typedef struct { int ch; longint pw; } res_t;

  samp_t  pend[$];
  res_t   mfifo[$];
  res_t   got[$];
  res_t   got6[$];
  longint m_sum [N_CH];
  int     m_cnt [N_CH];
  int     cyc = 0;
  int     freeze_until = -1;
  bit     m_over = 1'b0;

  int ovr_cnt, frz_hi, first_valid;
  bit sat6_seen;

  function automatic void model_clear_windows();
    pend.delete();
    for (int i = 0; i < N_CH; i++) begin
      m_sum[i] = 0;
      m_cnt[i] = 0;
    end
  endfunction

  function automatic void model_reset();
    model_clear_windows();
    mfifo.delete();
    freeze_until = -1;
    m_over = 1'b0;
  endfunction

  // A sample accepted in cycle c is integrated, and its window reported, at the edge that
  // ends cycle c+2; a saturated sample discards anything not yet integrated.
  function automatic void model_edge(input bit v, input int x, input int ch, input bit rdy);
    int    t = cyc;
    bit    frz = (t <= freeze_until);
    bit    inr = (ch < N_CH);
    bit    sat = v && inr && (x >= SAT_THRESH || -x >= SAT_THRESH);
    bit    push = 1'b0;
    bit    pop;
    res_t  r;
    samp_t s;
    longint lim = (longint'(1) << POW_W) - 1;
    r.ch = 0;
    r.pw = 0;
    m_over = 1'b0;
    if (sat) begin
      model_clear_windows();
    end else begin
      while (pend.size() > 0 && pend[0].cyc <= t - 2) begin
        s = pend.pop_front();
        m_sum[s.ch] += longint'(s.x) * longint'(s.x);
        m_cnt[s.ch]++;
        if (m_cnt[s.ch] == WIN) begin
          r.ch = s.ch;
          r.pw = m_sum[s.ch] >> WIN_LOG2;
          if (r.pw > lim) r.pw = lim;
          push = 1'b1;
          m_sum[s.ch] = 0;
          m_cnt[s.ch] = 0;
        end
      end
    end
    pop = (mfifo.size() > 0) && rdy;
    if (push && mfifo.size() == OUT_DEPTH && !pop) m_over = 1'b1;
    if (pop) void'(mfifo.pop_front());
    if (push && !m_over) mfifo.push_back(r);
    if (v && inr && !frz && !sat) begin
      s.cyc = t; s.ch = ch; s.x = x;
      pend.push_back(s);
    end
    if (sat) freeze_until = t + FREEZE_CYC;
    cyc++;
  endfunction

  task automatic compare_cycle();
    check("pow_valid", longint'(pow_valid), longint'(mfifo.size() > 0));
    if (mfifo.size() > 0) begin
      check("pow_out", longint'(pow_out), mfifo[0].pw);
      check("pow_ch", longint'(pow_ch), longint'(mfifo[0].ch));
    end
    check("overrun", longint'(overrun), longint'(m_over));
    check("sat_freeze", longint'(sat_freeze), longint'(cyc <= freeze_until));
  endtask

  // Called at a falling edge: drive one cycle of stimulus, advance model, compare.
  task automatic step(input bit v, input int x, input int ch, input bit rdy);
    res_t r;
    sample_valid = v;
    sample_in    = {16'(x), 8'($urandom)};
    sample_ch    = CH_W'(ch);
    pow_ready    = rdy;
    if (pow_valid && rdy) begin
      r.ch = int'(pow_ch); r.pw = longint'(pow_out);
      got.push_back(r);
    end
    if (pow_valid6 && rdy) begin
      r.ch = int'(pow_ch6); r.pw = longint'(pow_out6);
      got6.push_back(r);
    end
    @(posedge clk);
    model_edge(v, x, ch, rdy);
    @(negedge clk);
    compare_cycle();
    if (overrun) ovr_cnt++;
    if (sat_freeze) frz_hi++;
    if (sat_freeze6) sat6_seen = 1'b1;
    if (pow_valid && first_valid < 0) first_valid = cyc;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    pow_ready    = 1'b0;
    rst_n        = 1'b0;
    model_reset();
    #1;
    check("rst_pow_valid", longint'(pow_valid), 0);
    check("rst_pow_out", longint'(pow_out), 0);
    check("rst_pow_ch", longint'(pow_ch), 0);
    check("rst_sat_freeze", longint'(sat_freeze), 0);
    check("rst_overrun", longint'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    got6.delete();
    ovr_cnt = 0;
    frz_hi = 0;
    first_valid = -1;
    sat6_seen = 1'b0;
  endtask

  // 64 interleaved frames, ch0 carries +/-15000, other channels zero.
  task automatic window_test(input string tag, input int mode);
    int t0 = 0;
    int v;
    do_reset();
    for (int f = 0; f < WIN; f++) begin
      for (int c = 0; c < N_CH; c++) begin
        v = 0;
        if (c == 0) v = (mode == 1 || (mode == 2 && f % 2 == 1)) ? -15000 : 15000;
        if (c == 0 && f == WIN - 1) t0 = cyc;
        step(1'b1, v, c, 1'b1);
      end
    end
    idle(8, 1'b1);
    check($sformatf("%s_latency", tag), longint'(first_valid - t0), 3);
    check($sformatf("%s_count", tag), longint'(got.size()), N_CH);
    for (int i = 0; i < got.size() && i < N_CH; i++) begin
      check($sformatf("%s_ch%0d", tag, i), longint'(got[i].ch), longint'(i));
      check($sformatf("%s_pow%0d", tag, i), got[i].pw, (i == 0) ? 225000000 : 0);
    end
  endtask

  initial begin
    int t0;
    int x;
    int r;
    @(negedge clk);

    window_test("pos", 0);
    window_test("neg", 1);
    window_test("alt", 2);

    // Saturation mid-window: freeze, discard, and a full fresh window afterwards.
    do_reset();
    for (int f = 0; f < 20; f++)
      for (int c = 0; c < N_CH; c++) step(1'b1, (c == 0) ? 1000 : 0, c, 1'b1);
    frz_hi = 0;
    step(1'b1, 32767, 0, 1'b1);
    check("sat_next_cycle", longint'(sat_freeze), 1);
    idle(300, 1'b1);
    check("sat_hold_cycles", longint'(frz_hi), FREEZE_CYC);
    check("sat_no_output", longint'(got.size()), 0);
    for (int f = 0; f < WIN - 1; f++)
      for (int c = 0; c < N_CH; c++) step(1'b1, (c == 0) ? 1000 : 0, c, 1'b1);
    idle(8, 1'b1);
    check("sat_63_frames", longint'(got.size()), 0);
    for (int c = 0; c < N_CH; c++) step(1'b1, (c == 0) ? 1000 : 0, c, 1'b1);
    idle(8, 1'b1);
    check("sat_after_count", longint'(got.size()), N_CH);
    if (got.size() > 0) check("sat_after_pow", got[0].pw, 1000000);

    // Six back-to-back ch0 windows against a stalled consumer.
    do_reset();
    for (int w = 0; w < 6; w++)
      for (int i = 0; i < WIN; i++) step(1'b1, (w + 1) * 100, 0, 1'b0);
    idle(5, 1'b0);
    check("ovr_pulses", longint'(ovr_cnt), 2);
    check("ovr_held_valid", longint'(pow_valid), 1);
    idle(8, 1'b1);
    check("ovr_drained", longint'(got.size()), OUT_DEPTH);
    for (int i = 0; i < got.size() && i < OUT_DEPTH; i++)
      check($sformatf("ovr_pow%0d", i), got[i].pw, longint'((i + 1) * 100) * longint'((i + 1) * 100));

    // Out-of-range channels on the six-channel instance.
    do_reset();
    for (int f = 0; f < WIN; f++)
      for (int c = 0; c < 8; c++) step(1'b1, (c < 6) ? 2000 : 32767, c, 1'b1);
    idle(8, 1'b1);
    check("n6_no_freeze", longint'(sat6_seen), 0);
    check("n6_count", longint'(got6.size()), 6);
    for (int i = 0; i < got6.size() && i < 6; i++) begin
      check($sformatf("n6_ch%0d", i), longint'(got6[i].ch), longint'(i));
      check($sformatf("n6_pow%0d", i), got6[i].pw, 4000000);
    end

    // Reset after 40 samples discards the partial window.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 3000, 0, 1'b1);
    do_reset();
    for (int i = 0; i < WIN - 1; i++) step(1'b1, 3000, 0, 1'b1);
    idle(8, 1'b1);
    check("mrst_63", longint'(got.size()), 0);
    t0 = cyc;
    step(1'b1, 3000, 0, 1'b1);
    idle(8, 1'b1);
    check("mrst_latency", longint'(first_valid - t0), 3);
    check("mrst_count", longint'(got.size()), 1);
    if (got.size() > 0) check("mrst_pow", got[0].pw, 9000000);

    // Random traffic: two hot channels with a sluggish consumer, then full mix with saturation.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      x = int'($urandom_range(0, 60000)) - 30000;
      step($urandom_range(0, 99) < 90, x, $urandom_range(0, 1), $urandom_range(0, 99) < 30);
    end
    idle(20, 1'b1);
    for (int i = 0; i < 6000; i++) begin
      r = $urandom_range(0, 2999);
      if (r == 0)      x = 32767;
      else if (r == 1) x = -32768;
      else             x = int'($urandom_range(0, 40000)) - 20000;
      step($urandom_range(0, 99) < 85, x, $urandom_range(0, 7), $urandom_range(0, 99) < 70);
    end
    idle(20, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
